// File: rtl/pattern_detect_ctrl.sv
// Programmable serial bit-pattern detector with run/stop control, match counting and auto-stop.
// Pattern, length, overlap, Mealy/Moore output and target count are loaded while idle.
module pattern_detect_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               x,
  input  logic               x_valid,
  output logic               y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               moore_q, moore_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic               y_q, y_d;
  logic               err_q, err_d;

  logic               accept, match, pat_hit, fill_ok, len_ok, run_start;
  logic [MAX_LEN:0]   window, mask, pat_ext;
  logic [CNT_W-1:0]   cnt_inc;

  // Window is {hist, x}; only the low len bits take part in the compare.
  always_comb begin
    window  = {hist_q, x};
    pat_ext = {1'b0, pat_q};
    mask    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign pat_hit = (((window ^ pat_ext) & mask) == '0);
  assign fill_ok = (fill_q >= (len_q - LEN_W'(1)));
  assign accept  = (state_q == StRun) && x_valid;
  assign match   = accept && fill_ok && pat_hit;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    moore_d   = moore_q;
    tgt_d     = tgt_q;
    err_d     = 1'b0;
    y_d       = match && moore_q;
    run_start = 1'b0;

    if (cfg_we) begin
      if (state_q == StIdle && len_ok) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        moore_d = cfg_moore;
        tgt_d   = cfg_target;
      end else begin
        err_d = 1'b1;
      end
    end

    if (accept) begin
      hist_d = window[MAX_LEN-1:0];
      if (match && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    if (match) begin
      cnt_d = cnt_inc;
    end

    unique case (state_q)
      StIdle: begin
        if (!stop && start) run_start = 1'b1;
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (match && (tgt_q != '0) && (cnt_inc == tgt_q)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          run_start = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // The bit sampled on the start edge is discarded along with the old run's state.
    if (run_start) begin
      state_d = StRun;
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= MAX_LEN'(5);
      len_q   <= LEN_W'(3);
      ovl_q   <= 1'b1;
      moore_q <= 1'b0;
      tgt_q   <= '0;
      y_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      moore_q <= moore_d;
      tgt_q   <= tgt_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign y         = moore_q ? y_q : match;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed bench for pattern_detect_ctrl: hand-computed y, count, state and cfg_err expectations.
module tb_pattern_detect_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap, cfg_moore;
  logic [CNT_W-1:0]   cfg_target;
  logic               start, stop, x, x_valid;
  logic               y, busy, done, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  int n_vec = 0;
  int n_err = 0;

  pattern_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_moore   (cfg_moore),
    .cfg_target  (cfg_target),
    .start       (start),
    .stop        (stop),
    .x           (x),
    .x_valid     (x_valid),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic exp_y, input string tag);
    x       = b;
    x_valid = 1'b1;
    #1 chk(tag, {31'b0, y}, {31'b0, exp_y});
    next_cyc();
    x_valid = 1'b0;
    x       = 1'b0;
  endtask

  task automatic gap(input logic junk);
    x       = junk;
    x_valid = 1'b0;
    #1 chk("gap_y", {31'b0, y}, 32'd0);
    next_cyc();
    x = 1'b0;
  endtask

  task automatic ctl(input logic s, input logic p);
    start = s;
    stop  = p;
    next_cyc();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic moore, input logic [7:0] tgt, input logic exp_err);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_moore   = moore;
    cfg_target  = tgt;
    cfg_we      = 1'b1;
    next_cyc();
    cfg_we = 1'b0;
    #1 chk("cfg_err", {31'b0, cfg_err}, {31'b0, exp_err});
    next_cyc();
    #1 chk("cfg_err_clr", {31'b0, cfg_err}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_moore = 1'b0; cfg_target = '0;
    start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_y", {31'b0, y}, 32'd0);
    chk("rst_cnt", {24'b0, match_cnt}, 32'd0);
    chk("rst_err", {31'b0, cfg_err}, 32'd0);
    reset_n = 1'b1;
    next_cyc();

    // T1: default 101, overlapping, Mealy
    ctl(1'b1, 1'b0);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    send_bit(1, 0, "t1_b1"); send_bit(0, 0, "t1_b2"); send_bit(1, 1, "t1_b3");
    send_bit(0, 0, "t1_b4"); send_bit(1, 1, "t1_b5");
    chk("t1_cnt", {24'b0, match_cnt}, 32'd2);
    ctl(1'b0, 1'b1);
    chk("t1_idle", {31'b0, busy}, 32'd0);
    chk("t1_cnt_hold", {24'b0, match_cnt}, 32'd2);

    // T2: non-overlapping
    cfg(8'b101, 4'd3, 1'b0, 1'b0, 8'd0, 1'b0);
    ctl(1'b1, 1'b0);
    chk("t2_cnt_clr", {24'b0, match_cnt}, 32'd0);
    send_bit(1, 0, "t2_b1"); send_bit(0, 0, "t2_b2"); send_bit(1, 1, "t2_b3");
    send_bit(0, 0, "t2_b4"); send_bit(1, 0, "t2_b5");
    chk("t2_cnt", {24'b0, match_cnt}, 32'd1);
    ctl(1'b0, 1'b1);

    // T3: Moore output, one cycle late
    cfg(8'b101, 4'd3, 1'b1, 1'b1, 8'd0, 1'b0);
    ctl(1'b1, 1'b0);
    send_bit(1, 0, "t3_b1"); send_bit(0, 0, "t3_b2"); send_bit(1, 0, "t3_b3");
    #1 chk("t3_moore_hi", {31'b0, y}, 32'd1);
    next_cyc();
    #1 chk("t3_moore_lo", {31'b0, y}, 32'd0);
    ctl(1'b0, 1'b1);

    // T4: 0110 with auto-stop at 2 matches
    cfg(8'b0110, 4'd4, 1'b1, 1'b0, 8'd2, 1'b0);
    ctl(1'b1, 1'b0);
    send_bit(0, 0, "t4_b1"); send_bit(1, 0, "t4_b2"); send_bit(1, 0, "t4_b3");
    send_bit(0, 1, "t4_b4"); send_bit(1, 0, "t4_b5"); send_bit(1, 0, "t4_b6");
    send_bit(0, 1, "t4_b7");
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_done", {31'b0, done}, 32'd1);
    send_bit(1, 0, "t4_b8"); send_bit(1, 0, "t4_b9"); send_bit(0, 0, "t4_b10");
    chk("t4_cnt_frozen", {24'b0, match_cnt}, 32'd2);
    chk("t4_still_done", {31'b0, done}, 32'd1);
    ctl(1'b1, 1'b0);
    chk("t4_rerun", {31'b0, busy}, 32'd1);
    chk("t4_cnt_rerun", {24'b0, match_cnt}, 32'd0);
    ctl(1'b0, 1'b1);

    // T5: illegal lengths and cfg_we while running are rejected
    cfg(8'b101, 4'd3, 1'b1, 1'b0, 8'd0, 1'b0);
    cfg(8'b0110, 4'd0, 1'b0, 1'b1, 8'd1, 1'b1);
    cfg(8'b0110, 4'd9, 1'b0, 1'b1, 8'd1, 1'b1);
    ctl(1'b1, 1'b0);
    cfg(8'b111, 4'd3, 1'b0, 1'b1, 8'd1, 1'b1);
    chk("t5_busy", {31'b0, busy}, 32'd1);
    send_bit(1, 0, "t5_b1"); send_bit(0, 0, "t5_b2"); send_bit(1, 1, "t5_b3");
    send_bit(0, 0, "t5_b4"); send_bit(1, 1, "t5_b5");
    ctl(1'b0, 1'b1);

    // T6: x_valid gaps, start+stop, match+stop, async reset
    ctl(1'b1, 1'b0);
    send_bit(1, 0, "t6_b1"); gap(1'b1); send_bit(0, 0, "t6_b2"); gap(1'b0);
    send_bit(1, 1, "t6_b3");
    chk("t6_cnt", {24'b0, match_cnt}, 32'd1);
    ctl(1'b1, 1'b1);
    chk("t6_ss_run", {31'b0, busy}, 32'd0);
    ctl(1'b1, 1'b1);
    chk("t6_ss_idle", {31'b0, busy}, 32'd0);
    ctl(1'b1, 1'b0);
    send_bit(1, 0, "t6_m1"); send_bit(0, 0, "t6_m2");
    stop = 1'b1;
    send_bit(1, 1, "t6_m3_stop");
    stop = 1'b0;
    chk("t6_ms_idle", {31'b0, busy}, 32'd0);
    chk("t6_ms_cnt", {24'b0, match_cnt}, 32'd1);

    cfg(8'b0110, 4'd4, 1'b0, 1'b1, 8'd3, 1'b0);
    ctl(1'b1, 1'b0);
    send_bit(0, 0, "t6_r1"); send_bit(1, 0, "t6_r2"); send_bit(1, 0, "t6_r3");
    send_bit(0, 0, "t6_r4");
    #1 chk("t6_pre_rst_cnt", {24'b0, match_cnt}, 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_cnt", {24'b0, match_cnt}, 32'd0);
    chk("t6_rst_y", {31'b0, y}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cyc();
    ctl(1'b1, 1'b0);
    send_bit(1, 0, "t6_d1"); send_bit(0, 0, "t6_d2"); send_bit(1, 1, "t6_d3");
    send_bit(0, 0, "t6_d4"); send_bit(1, 1, "t6_d5");
    chk("t6_d_cnt", {24'b0, match_cnt}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
